// File: rtl/vga_timing_if.sv
// Raster timing bundle carried from vga_timing to the drawing stages.
// frame_cnt is present only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if;
    logic [10:0] hcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic [10:0] vcount_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic        frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    modport master (
        output hcount_out, hsync_out, hblnk_out,
        output vcount_out, vsync_out, vblnk_out,
        output frame_start, frame_cnt
    );
    modport slave (
        input hcount_out, hsync_out, hblnk_out,
        input vcount_out, vsync_out, vblnk_out,
        input frame_start, frame_cnt
    );
`else
    modport master (
        output hcount_out, hsync_out, hblnk_out,
        output vcount_out, vsync_out, vblnk_out,
        output frame_start
    );
    modport slave (
        input hcount_out, hsync_out, hblnk_out,
        input vcount_out, vsync_out, vblnk_out,
        input frame_start
    );
`endif
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator (default 800x600@60, 40 MHz pixel clock, positive syncs).
// Optional per-frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
    parameter int H_VISIBLE = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23
) (
    input  logic         pclk,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Thresholds are 12 bits so a sync window ending exactly at 2048 does not truncate.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [11:0] HB_START = 12'(H_VISIBLE);
    localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [11:0] VB_START = 12'(V_VISIBLE);
    localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FP + V_SYNC);

    generate
        if ((H_TOTAL > 32'sd2048) || (V_TOTAL > 32'sd2048)) begin : g_bad_params
            $error("vga_timing: H_TOTAL or V_TOTAL exceeds the 11-bit counter range");
        end
    endgenerate

    logic [10:0] hcount_r;
    logic [10:0] vcount_r;
    logic        hsync_r;
    logic        hblnk_r;
    logic        vsync_r;
    logic        vblnk_r;
    logic        frame_start_r;

    logic        h_wrap_s;
    logic        v_wrap_s;
    logic [10:0] hcount_nxt_s;
    logic [10:0] vcount_nxt_s;
    logic        hsync_nxt_s;
    logic        hblnk_nxt_s;
    logic        vsync_nxt_s;
    logic        vblnk_nxt_s;
    logic        frame_start_nxt_s;

    // Next raster position and flags decoded from it, so flags register in step with the counters.
    always_comb begin
        h_wrap_s          = (hcount_r == H_LAST);
        v_wrap_s          = (vcount_r == V_LAST);
        hcount_nxt_s      = hcount_r + 11'd1;
        vcount_nxt_s      = vcount_r;
        if (h_wrap_s) begin
            hcount_nxt_s = 11'd0;
            if (v_wrap_s) begin
                vcount_nxt_s = 11'd0;
            end else begin
                vcount_nxt_s = vcount_r + 11'd1;
            end
        end else begin
            vcount_nxt_s = vcount_r;
        end
        hblnk_nxt_s       = ({1'b0, hcount_nxt_s} >= HB_START);
        hsync_nxt_s       = ({1'b0, hcount_nxt_s} >= HS_START) && ({1'b0, hcount_nxt_s} < HS_END);
        vblnk_nxt_s       = ({1'b0, vcount_nxt_s} >= VB_START);
        vsync_nxt_s       = ({1'b0, vcount_nxt_s} >= VS_START) && ({1'b0, vcount_nxt_s} < VS_END);
        frame_start_nxt_s = h_wrap_s && v_wrap_s;
    end

    // Raster state; reset parks at (0,0) with every flag low, including frame_start.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hcount_r      <= 11'd0;
            vcount_r      <= 11'd0;
            hsync_r       <= 1'b0;
            hblnk_r       <= 1'b0;
            vsync_r       <= 1'b0;
            vblnk_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hcount_r      <= hcount_nxt_s;
            vcount_r      <= vcount_nxt_s;
            hsync_r       <= hsync_nxt_s;
            hblnk_r       <= hblnk_nxt_s;
            vsync_r       <= vsync_nxt_s;
            vblnk_r       <= vblnk_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

    assign vga.hcount_out  = hcount_r;
    assign vga.vcount_out  = vcount_r;
    assign vga.hsync_out   = hsync_r;
    assign vga.hblnk_out   = hblnk_r;
    assign vga.vsync_out   = vsync_r;
    assign vga.vblnk_out   = vblnk_r;
    assign vga.frame_start = frame_start_r;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame label advances on the edge that raises frame_start, wrapping naturally at 16 bits.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_start_nxt_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign vga.frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-mode instance for line-level checks and a
// shrunken-raster instance so whole frames fit in a short run.
module tb_vga_timing;
    localparam int D_HV = 800, D_HFP = 40, D_HS = 128, D_HBP = 88;
    localparam int D_VV = 600, D_VFP = 1,  D_VS = 4,   D_VBP = 23;
    localparam int S_HV = 20,  S_HFP = 3,  S_HS = 5,   S_HBP = 4;
    localparam int S_VV = 12,  S_VFP = 2,  S_VS = 3,   S_VBP = 3;
    localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;
    localparam int S_FT = S_HT * S_VT;

    logic   pclk  = 1'b0;
    logic   reset = 1'b1;
    int     total = 0;
    int     bad   = 0;
    longint t;

    vga_timing_if vif_d ();
    vga_timing_if vif_s ();

    vga_timing dut_d (.pclk(pclk), .reset(reset), .vga(vif_d));
    vga_timing #(
        .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) dut_s (.pclk(pclk), .reset(reset), .vga(vif_s));

    always #5 pclk = ~pclk;

    // Model time: rising edges seen since reset was last released.
    always @(posedge pclk or posedge reset) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    // Expected outputs after tt post-reset edges: position is tt modulo the frame size.
    function automatic logic [26:0] model(input longint tt, input int hv, hfp, hs, hbp,
                                          input int vv, vfp, vs, vbp);
        int ht, vt, h, v;
        longint p;
        logic hsync, hblnk, vsync, vblnk, fs;
        ht    = hv + hfp + hs + hbp;
        vt    = vv + vfp + vs + vbp;
        p     = tt % longint'(ht * vt);
        h     = int'(p % ht);
        v     = int'(p / ht);
        hblnk = (h >= hv);
        hsync = (h >= hv + hfp) && (h < hv + hfp + hs);
        vblnk = (v >= vv);
        vsync = (v >= vv + vfp) && (v < vv + vfp + vs);
        fs    = (p == 0) && (tt > 0);
        return {11'(h), 11'(v), hsync, hblnk, vsync, vblnk, fs};
    endfunction

    function automatic logic [26:0] obs_d();
        return {vif_d.hcount_out, vif_d.vcount_out, vif_d.hsync_out, vif_d.hblnk_out,
                vif_d.vsync_out, vif_d.vblnk_out, vif_d.frame_start};
    endfunction

    function automatic logic [26:0] obs_s();
        return {vif_s.hcount_out, vif_s.vcount_out, vif_s.hsync_out, vif_s.hblnk_out,
                vif_s.vsync_out, vif_s.vblnk_out, vif_s.frame_start};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            total++;
            if (obs_d() !== 27'd0) begin
                bad++; $display("FAIL reset_hold_d cyc=%0d got=%h want=0", i, obs_d());
            end
            total++;
            if (obs_s() !== 27'd0) begin
                bad++; $display("FAIL reset_hold_s cyc=%0d got=%h want=0", i, obs_s());
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            total++;
            if (vif_s.frame_cnt !== 16'd0) begin
                bad++; $display("FAIL reset_frame_cnt got=%0d want=0", vif_s.frame_cnt);
            end
`endif
        end
        reset = 1'b0;
        @(negedge pclk);
        total++;
        if (obs_d() !== {11'd1, 11'd0, 5'b00000}) begin
            bad++; $display("FAIL first_edge_d got=%h want=%h", obs_d(), {11'd1, 11'd0, 5'b00000});
        end
        total++;
        if (obs_s() !== {11'd1, 11'd0, 5'b00000}) begin
            bad++; $display("FAIL first_edge_s got=%h want=%h", obs_s(), {11'd1, 11'd0, 5'b00000});
        end
    endtask

    task automatic test_line();
        int          hs_cnt = 0;
        int          hb_rise = -1;
        logic        prev_hb = 1'b0;
        logic [26:0] e;
        for (int i = 0; i < 1100; i++) begin
            @(negedge pclk);
            e = model(t, D_HV, D_HFP, D_HS, D_HBP, D_VV, D_VFP, D_VS, D_VBP);
            total++;
            if (obs_d() !== e) begin
                bad++; $display("FAIL line_d t=%0d got=%h want=%h", t, obs_d(), e);
            end
            if (vif_d.vcount_out == 11'd0 && vif_d.hsync_out) hs_cnt++;
            if (vif_d.hblnk_out && !prev_hb && hb_rise < 0) hb_rise = int'(vif_d.hcount_out);
            prev_hb = vif_d.hblnk_out;
            if (vif_d.hcount_out == 11'd0) begin
                total++;
                if (vif_d.vcount_out !== 11'd1) begin
                    bad++; $display("FAIL line_wrap_v got=%0d want=1", vif_d.vcount_out);
                end
            end
        end
        total++;
        if (hs_cnt != 128) begin
            bad++; $display("FAIL hsync_width got=%0d want=128", hs_cnt);
        end
        total++;
        if (hb_rise != 800) begin
            bad++; $display("FAIL hblnk_rise got=%0d want=800", hb_rise);
        end
    endtask

    task automatic test_frames();
        int          n;
        int          vs_cnt = 0;
        longint      last_fs = -1;
        logic [26:0] e;
        n = 2 * S_FT + int'($urandom_range(0, 60));
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            e = model(t, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP);
            total++;
            if (obs_s() !== e) begin
                bad++; $display("FAIL frames_s t=%0d got=%h want=%h", t, obs_s(), e);
            end
            if (vif_s.frame_start) begin
                if (last_fs >= 0) begin
                    total++;
                    if (t - last_fs != S_FT) begin
                        bad++; $display("FAIL fs_period got=%0d want=%0d", t - last_fs, S_FT);
                    end
                    total++;
                    if (vs_cnt != S_VS * S_HT) begin
                        bad++; $display("FAIL vsync_len got=%0d want=%0d", vs_cnt, S_VS * S_HT);
                    end
                end
                last_fs = t;
                vs_cnt  = 0;
            end
            if (vif_s.vsync_out) vs_cnt++;
        end
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        for (int i = 0; i < S_FT + 4 && !found; i++) begin
            @(negedge pclk);
            if (vif_s.hcount_out == 11'(S_HT - 1) && vif_s.vcount_out == 11'(S_VT - 1)) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL wrap_timeout got=none want=(%0d,%0d)", S_HT - 1, S_VT - 1);
        end else begin
            total++;
            if ({vif_s.hblnk_out, vif_s.vblnk_out, vif_s.frame_start} !== 3'b110) begin
                bad++; $display("FAIL wrap_before got=%b want=110",
                                {vif_s.hblnk_out, vif_s.vblnk_out, vif_s.frame_start});
            end
            @(negedge pclk);
            total++;
            if (obs_s() !== {22'd0, 5'b00001}) begin
                bad++; $display("FAIL wrap_after got=%h want=%h", obs_s(), {22'd0, 5'b00001});
            end
        end
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 3; r++) begin
            logic [10:0] th, tv;
            bit          found = 1'b0;
            longint      fs_t = -1;
            logic [26:0] e;
            th = 11'($urandom_range(0, S_HT - 1));
            tv = 11'($urandom_range(0, S_VT - 1));
            for (int i = 0; i < S_FT + 4 && !found; i++) begin
                @(negedge pclk);
                if (vif_s.hcount_out == th && vif_s.vcount_out == tv) found = 1'b1;
            end
            total++;
            if (!found) begin
                bad++; $display("FAIL areset_seek got=none want=(%0d,%0d)", th, tv);
            end
            #2 reset = 1'b1;
            #1;
            total++;
            if (obs_s() !== 27'd0 || obs_d() !== 27'd0) begin
                bad++; $display("FAIL areset_immediate got=%h/%h want=0", obs_s(), obs_d());
            end
            repeat ($urandom_range(1, 5)) @(negedge pclk);
            reset = 1'b0;
            for (int n = 0; n < S_FT + 4 && fs_t < 0; n++) begin
                @(negedge pclk);
                e = model(t, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP);
                total++;
                if (obs_s() !== e) begin
                    bad++; $display("FAIL areset_run t=%0d got=%h want=%h", t, obs_s(), e);
                end
                if (vif_s.frame_start) fs_t = t;
            end
            total++;
            if (fs_t - 1 != S_FT - 1) begin
                bad++; $display("FAIL areset_first_fs got=%0d want=%0d", fs_t - 1, S_FT - 1);
            end
        end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * S_FT + 5; i++) begin
            @(negedge pclk);
            total++;
            if (vif_s.frame_cnt !== 16'(t / S_FT)) begin
                bad++; $display("FAIL frame_cnt t=%0d got=%0d want=%0d", t, vif_s.frame_cnt, 16'(t / S_FT));
            end
        end
        @(negedge pclk);
        force dut_s.frame_cnt_r = 16'hFFFF;
        #1 release dut_s.frame_cnt_r;
        for (int i = 0; i < S_FT + 4 && !seen; i++) begin
            @(negedge pclk);
            if (vif_s.frame_start) seen = 1'b1;
        end
        total++;
        if (!seen || vif_s.frame_cnt !== 16'd0) begin
            bad++; $display("FAIL frame_cnt_wrap seen=%0d got=%0d want=0", seen, vif_s.frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_wrap();
        test_async_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
